// File: rtl/triangle_raster_writer_if.sv
// Triangle-descriptor and framebuffer-write bundle for triangle_raster_writer.
// Depth-buffer signals exist only when DEPTH_TEST_EN is defined.
interface triangle_raster_writer_if #(
    parameter int CORDW = 10,
    parameter int ADDRW = 19,
    parameter int COLRW = 12
);
    logic             tri_valid;
    logic             tri_ready;
    logic [CORDW-1:0] x0, y0, x1, y1, x2, y2;
    logic [COLRW-1:0] tri_color;
    logic             fb_we;
    logic [ADDRW-1:0] fb_addr;
    logic [COLRW-1:0] fb_data;
    logic             fb_ready;
`ifdef DEPTH_TEST_EN
    logic [15:0]      tri_z;
    logic [ADDRW-1:0] zb_rd_addr;
    logic [15:0]      zb_rd_data;
    logic             zb_we;
    logic [15:0]      zb_wdata;
`endif

    modport master (
`ifdef DEPTH_TEST_EN
        output tri_z, zb_rd_data,
        input  zb_rd_addr, zb_we, zb_wdata,
`endif
        output tri_valid, x0, y0, x1, y1, x2, y2, tri_color, fb_ready,
        input  tri_ready, fb_we, fb_addr, fb_data
    );

    modport slave (
`ifdef DEPTH_TEST_EN
        input  tri_z, zb_rd_data,
        output zb_rd_addr, zb_we, zb_wdata,
`endif
        input  tri_valid, x0, y0, x1, y1, x2, y2, tri_color, fb_ready,
        output tri_ready, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/triangle_raster_writer.sv
// Scans a flat-coloured triangle's clamped bounding box one pixel per cycle and
// writes covered pixels to the framebuffer. Optional z-test: define DEPTH_TEST_EN.
module triangle_raster_writer #(
    parameter int CORDW = 10,
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int ADDRW = 19,
    parameter int COLRW = 12
) (
    input  logic                      clk_pix,
    input  logic                      rst_pix,
    triangle_raster_writer_if.slave   bus,
    output logic                      busy,
    output logic                      done
);
    localparam int EW = 2*CORDW + 3;
    localparam logic [CORDW-1:0] XLIM = CORDW'(H_RES - 1);
    localparam logic [CORDW-1:0] YLIM = CORDW'(V_RES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;
`ifdef DEPTH_TEST_EN
    typedef enum logic [1:0] {PH_PIX, PH_RD, PH_CMP} phase_t;
`endif

    function automatic logic signed [EW-1:0] ext(input logic [CORDW-1:0] v);
        return $signed({{(EW-CORDW){1'b0}}, v});
    endfunction

    // (bx-ax)(py-ay) - (by-ay)(px-ax); operands fit well inside EW bits so truncation is exact
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [CORDW-1:0] ax, ay, bx, by, px, py);
        return (ext(bx) - ext(ax)) * (ext(py) - ext(ay))
             - (ext(by) - ext(ay)) * (ext(px) - ext(ax));
    endfunction

    function automatic logic [CORDW-1:0] min3(input logic [CORDW-1:0] a, b, c);
        logic [CORDW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [CORDW-1:0] max3(input logic [CORDW-1:0] a, b, c);
        logic [CORDW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic is_zero_or_neg(input logic signed [EW-1:0] w);
        return w[EW-1] || (w == {EW{1'b0}});
    endfunction

    // Negative winding flips the inequality instead of negating the edge values.
    function automatic logic covered(input logic signed [EW-1:0] w0, w1, w2, input logic neg);
        if (neg) begin
            return is_zero_or_neg(w0) && is_zero_or_neg(w1) && is_zero_or_neg(w2);
        end else begin
            return !w0[EW-1] && !w1[EW-1] && !w2[EW-1];
        end
    endfunction

    state_t           state_q, state_d;
    logic [CORDW-1:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic [CORDW-1:0] x0_d, y0_d, x1_d, y1_d, x2_d, y2_d;
    logic [COLRW-1:0] color_q, color_d;
    logic [CORDW-1:0] xmin_q, xmax_q, ymax_q, xmin_d, xmax_d, ymax_d;
    logic [CORDW-1:0] cx_q, cy_q, cx_d, cy_d;
    logic             neg_q, neg_d;
    logic             fb_we_q, fb_we_d;
    logic [ADDRW-1:0] fb_addr_q, fb_addr_d;
    logic             tri_ready_q, tri_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DEPTH_TEST_EN
    phase_t           phase_q, phase_d;
    logic [15:0]      z_q, z_d;
    logic [ADDRW-1:0] zb_rd_addr_q, zb_rd_addr_d;
`endif

    logic [CORDW-1:0]       bb_xmin_s, bb_ymin_s, bb_xmax_s, bb_ymax_s, raw_xmax_s, raw_ymax_s;
    logic                   bb_empty_s;
    logic signed [EW-1:0]   area_s, w0_s, w1_s, w2_s;
    logic [CORDW-1:0]       adv_x_s, adv_y_s, px_s, py_s;
    logic                   neg_s, cov_s, last_s, pix_done_s;
    logic [ADDRW-1:0]       addr_s;

    // Next-state: setup math, coverage of the next pixel to present, handshake.
    always_comb begin
        state_d     = state_q;
        x0_d = x0_q; y0_d = y0_q; x1_d = x1_q; y1_d = y1_q; x2_d = x2_q; y2_d = y2_q;
        color_d     = color_q;
        xmin_d      = xmin_q;
        xmax_d      = xmax_q;
        ymax_d      = ymax_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        neg_d       = neg_q;
        fb_we_d     = fb_we_q;
        fb_addr_d   = fb_addr_q;
        pix_done_s  = 1'b0;
`ifdef DEPTH_TEST_EN
        phase_d      = phase_q;
        z_d          = z_q;
        zb_rd_addr_d = zb_rd_addr_q;
`endif

        bb_xmin_s  = min3(x0_q, x1_q, x2_q);
        bb_ymin_s  = min3(y0_q, y1_q, y2_q);
        raw_xmax_s = max3(x0_q, x1_q, x2_q);
        raw_ymax_s = max3(y0_q, y1_q, y2_q);
        bb_xmax_s  = (raw_xmax_s > XLIM) ? XLIM : raw_xmax_s;
        bb_ymax_s  = (raw_ymax_s > YLIM) ? YLIM : raw_ymax_s;
        bb_empty_s = (bb_xmin_s > XLIM) || (bb_ymin_s > YLIM);
        area_s     = edge_fn(x0_q, y0_q, x1_q, y1_q, x2_q, y2_q);

        last_s = (cx_q == xmax_q) && (cy_q == ymax_q);
        if (cx_q == xmax_q) begin
            adv_x_s = xmin_q;
            adv_y_s = cy_q + CORDW'(1);
        end else begin
            adv_x_s = cx_q + CORDW'(1);
            adv_y_s = cy_q;
        end

        if (state_q == S_SETUP) begin
            px_s  = bb_xmin_s;
            py_s  = bb_ymin_s;
            neg_s = area_s[EW-1];
        end else begin
            px_s  = adv_x_s;
            py_s  = adv_y_s;
            neg_s = neg_q;
        end

        w0_s   = edge_fn(x1_q, y1_q, x2_q, y2_q, px_s, py_s);
        w1_s   = edge_fn(x2_q, y2_q, x0_q, y0_q, px_s, py_s);
        w2_s   = edge_fn(x0_q, y0_q, x1_q, y1_q, px_s, py_s);
        cov_s  = covered(w0_s, w1_s, w2_s, neg_s);
        addr_s = ADDRW'(py_s) * ADDRW'(H_RES) + ADDRW'(px_s);

        case (state_q)
            S_IDLE: begin
                if (bus.tri_valid && tri_ready_q) begin
                    x0_d = bus.x0; y0_d = bus.y0; x1_d = bus.x1;
                    y1_d = bus.y1; x2_d = bus.x2; y2_d = bus.y2;
                    color_d = bus.tri_color;
`ifdef DEPTH_TEST_EN
                    z_d     = bus.tri_z;
`endif
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if ((area_s == {EW{1'b0}}) || bb_empty_s) begin
                    state_d = S_DONE;
                end else begin
                    neg_d     = neg_s;
                    xmin_d    = bb_xmin_s;
                    xmax_d    = bb_xmax_s;
                    ymax_d    = bb_ymax_s;
                    cx_d      = px_s;
                    cy_d      = py_s;
                    fb_addr_d = addr_s;
`ifdef DEPTH_TEST_EN
                    fb_we_d      = 1'b0;
                    phase_d      = cov_s ? PH_RD : PH_PIX;
                    zb_rd_addr_d = addr_s;
`else
                    fb_we_d   = cov_s;
`endif
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
`ifdef DEPTH_TEST_EN
                case (phase_q)
                    PH_RD:   phase_d = PH_CMP;
                    PH_CMP: begin
                        if (z_q < bus.zb_rd_data) begin
                            fb_we_d = 1'b1;
                            phase_d = PH_PIX;
                        end else begin
                            pix_done_s = 1'b1;
                        end
                    end
                    default: pix_done_s = !fb_we_q || bus.fb_ready;
                endcase
`else
                pix_done_s = !fb_we_q || bus.fb_ready;
`endif
                if (pix_done_s) begin
                    if (last_s) begin
                        fb_we_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        cx_d      = px_s;
                        cy_d      = py_s;
                        fb_addr_d = addr_s;
`ifdef DEPTH_TEST_EN
                        fb_we_d      = 1'b0;
                        phase_d      = cov_s ? PH_RD : PH_PIX;
                        zb_rd_addr_d = addr_s;
`else
                        fb_we_d   = cov_s;
`endif
                    end
                end else begin
                    state_d = S_SCAN;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        tri_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State and registered outputs; reset abandons any triangle in flight.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state_q     <= S_IDLE;
            x0_q <= '0; y0_q <= '0; x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0;
            color_q     <= '0;
            xmin_q      <= '0;
            xmax_q      <= '0;
            ymax_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            neg_q       <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            tri_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef DEPTH_TEST_EN
            phase_q      <= PH_PIX;
            z_q          <= '0;
            zb_rd_addr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            x0_q <= x0_d; y0_q <= y0_d; x1_q <= x1_d; y1_q <= y1_d; x2_q <= x2_d; y2_q <= y2_d;
            color_q     <= color_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymax_q      <= ymax_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            neg_q       <= neg_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            tri_ready_q <= tri_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef DEPTH_TEST_EN
            phase_q      <= phase_d;
            z_q          <= z_d;
            zb_rd_addr_q <= zb_rd_addr_d;
`endif
        end
    end

    assign bus.tri_ready = tri_ready_q;
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = color_q;
`ifdef DEPTH_TEST_EN
    assign bus.zb_rd_addr = zb_rd_addr_q;
    assign bus.zb_we      = fb_we_q;
    assign bus.zb_wdata   = z_q;
`endif
    assign busy = busy_q;
    assign done = done_q;
endmodule
